// File: rtl/debounce_scheduler.sv
// Time-multiplexed switch debouncer: one shared 3-sample debounce engine visits
// each channel in round-robin order, once per service tick.
module debounce_scheduler #(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 1_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic [N_CH-1:0]         i_sw,
    output logic [N_CH-1:0]         o_db,
    output logic [N_CH-1:0]         o_db_pulse,
    output logic [N_CH*8-1:0]       o_count,
    output logic [$clog2(N_CH)-1:0] o_ch_sel,
    output logic                    o_tick
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        W1A  = 3'd1,
        W1B  = 3'd2,
        ONE  = 3'd3,
        W0A  = 3'd4,
        W0B  = 3'd5
    } db_state_t;

    logic [N_CH-1:0]  sync1_reg;
    logic [N_CH-1:0]  sync2_reg;
    logic [DIV_W-1:0] div_reg;
    logic [CH_W-1:0]  ch_sel_reg;
    db_state_t        state_reg [N_CH];
    logic [N_CH-1:0]  db_reg;
    logic [N_CH-1:0]  pulse_reg;
    logic [7:0]       count_reg [N_CH];

    logic      tick;
    db_state_t cur_state;
    db_state_t state_next;
    logic      sample;
    logic      db_next;
    logic      rise;

    assign tick = i_en && (div_reg == DIV_LAST);

    // Shared engine: evaluates only the channel currently selected.
    always_comb begin
        cur_state  = state_reg[ch_sel_reg];
        sample     = sync2_reg[ch_sel_reg];
        state_next = cur_state;
        case (cur_state)
            ZERO:    state_next = sample ? W1A : ZERO;
            W1A:     state_next = sample ? W1B : ZERO;
            W1B:     state_next = sample ? ONE : ZERO;
            ONE:     state_next = sample ? ONE : W0A;
            W0A:     state_next = sample ? ONE : W0B;
            W0B:     state_next = sample ? ONE : ZERO;
            default: state_next = ZERO;
        endcase
        db_next = (state_next == ONE) || (state_next == W0A) || (state_next == W0B);
        rise    = (cur_state == W1B) && sample;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            div_reg    <= '0;
            ch_sel_reg <= '0;
            db_reg     <= '0;
            pulse_reg  <= '0;
            for (int k = 0; k < N_CH; k++) begin
                state_reg[k] <= ZERO;
                count_reg[k] <= 8'd0;
            end
        end else begin
            sync1_reg <= i_sw;
            sync2_reg <= sync1_reg;
            pulse_reg <= '0;
            if (i_en) begin
                div_reg <= tick ? '0 : div_reg + DIV_W'(1);
            end
            if (tick) begin
                state_reg[ch_sel_reg] <= state_next;
                db_reg[ch_sel_reg]    <= db_next;
                pulse_reg[ch_sel_reg] <= rise;
                ch_sel_reg            <= (ch_sel_reg == CH_LAST) ? '0 : ch_sel_reg + CH_W'(1);
            end
            // Clear takes priority over a coincident increment.
            for (int k = 0; k < N_CH; k++) begin
                if (i_clr) begin
                    count_reg[k] <= 8'd0;
                end else if (tick && rise && (ch_sel_reg == CH_W'(k))) begin
                    count_reg[k] <= count_reg[k] + 8'd1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_count
            assign o_count[8*gi +: 8] = count_reg[gi];
        end
    endgenerate

    assign o_db       = db_reg;
    assign o_db_pulse = pulse_reg;
    assign o_ch_sel   = ch_sel_reg;
    assign o_tick     = tick;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with N_CH=4, TICK_DIV=4 (16-cycle channel period).
module tb_debounce_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [3:0]  sw;
    logic [3:0]  db;
    logic [3:0]  db_pulse;
    logic [31:0] count;
    logic [1:0]  ch_sel;
    logic        tick;

    int n_cmp  = 0;
    int n_fail = 0;
    int tick_cnt = 0;
    int pulse_cnt [4] = '{0, 0, 0, 0};

    typedef struct {
        logic       sw0;
        logic       exp_db0;
        logic [7:0] exp_cnt0;
    } vec_t;

    vec_t vecs [16];

    debounce_scheduler #(.N_CH(4), .TICK_DIV(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_en       (en),
        .i_clr      (clr),
        .i_sw       (sw),
        .o_db       (db),
        .o_db_pulse (db_pulse),
        .o_count    (count),
        .o_ch_sel   (ch_sel),
        .o_tick     (tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick) tick_cnt++;
        for (int k = 0; k < 4; k++) pulse_cnt[k] += int'(db_pulse[k]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the cycle whose closing edge services channel ch.
    task automatic wait_tick(input int ch);
        int n = 0;
        while (!(tick && ch_sel == 2'(ch)) && n < 300) begin
            step(1);
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_tick ch%0d: no tick within %0d cycles", ch, n);
        end
    endtask

    task automatic to_tick_edge(input int ch);
        wait_tick(ch);
        step(1);
    endtask

    initial begin
        int saved_sel;
        int saved_ticks;
        int saved_p0;

        vecs[0]  = '{1'b0, 1'b1, 8'd1};
        vecs[1]  = '{1'b1, 1'b1, 8'd1};
        vecs[2]  = '{1'b0, 1'b1, 8'd1};
        vecs[3]  = '{1'b0, 1'b1, 8'd1};
        vecs[4]  = '{1'b0, 1'b0, 8'd1};
        vecs[5]  = '{1'b1, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 1'b0, 8'd1};
        vecs[7]  = '{1'b1, 1'b0, 8'd1};
        vecs[8]  = '{1'b1, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b1, 1'b0, 8'd1};
        vecs[11] = '{1'b1, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 1'b1, 8'd2};
        vecs[13] = '{1'b0, 1'b1, 8'd2};
        vecs[14] = '{1'b0, 1'b1, 8'd2};
        vecs[15] = '{1'b1, 1'b1, 8'd2};

        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        sw    = 4'b0001;
        step(3);
        check("reset db", 32'(db), 32'h0);
        check("reset pulse", 32'(db_pulse), 32'h0);
        check("reset count", count, 32'h0);
        check("reset ch_sel", 32'(ch_sel), 32'h0);
        check("reset tick", 32'(tick), 32'h0);

        // First tick after TICK_DIV enabled edges, channel 0 first.
        rst_n = 1'b1;
        step(2);
        check("no early tick", 32'(tick), 32'h0);
        step(1);
        check("first tick", 32'(tick), 32'h1);
        check("first ch_sel", 32'(ch_sel), 32'h0);
        step(1);
        check("ch0 svc1 db", 32'(db[0]), 32'h0);
        to_tick_edge(0);
        check("ch0 svc2 db", 32'(db[0]), 32'h0);
        to_tick_edge(0);
        check("ch0 svc3 db", 32'(db), 32'h1);
        check("ch0 svc3 pulse", 32'(db_pulse), 32'h1);
        check("ch0 svc3 count", count, 32'h0000_0001);
        step(1);
        check("ch0 pulse one cycle", 32'(db_pulse), 32'h0);
        wait_tick(0);
        step(1);

        for (int i = 0; i < 16; i++) begin
            sw[0] = vecs[i].sw0;
            to_tick_edge(0);
            check($sformatf("vec%0d db0", i), 32'(db[0]), 32'(vecs[i].exp_db0));
            check($sformatf("vec%0d cnt0", i), 32'(count[7:0]), 32'(vecs[i].exp_cnt0));
        end
        check("table pulses ch0", pulse_cnt[0], 2);

        // 20-cycle glitch on channel 1 never reaches three services.
        sw[1] = 1'b1;
        step(20);
        sw[1] = 1'b0;
        step(64);
        check("glitch db1", 32'(db[1]), 32'h0);
        check("glitch cnt1", 32'(count[15:8]), 32'h0);
        check("glitch pulses1", pulse_cnt[1], 0);

        // Enable drop mid-debounce on channel 2.
        to_tick_edge(2);
        sw[2] = 1'b1;
        to_tick_edge(2);
        check("ch2 W1A db", 32'(db[2]), 32'h0);
        en = 1'b0;
        saved_sel   = int'(ch_sel);
        saved_ticks = tick_cnt;
        step(50);
        check("en low ch_sel held", 32'(ch_sel), 32'(saved_sel));
        check("en low no ticks", tick_cnt, saved_ticks);
        en = 1'b1;
        to_tick_edge(2);
        check("ch2 resume W1B db", 32'(db[2]), 32'h0);
        to_tick_edge(2);
        check("ch2 resume ONE db", 32'(db[2]), 32'h1);
        check("ch2 resume count", count, 32'h0001_0002);

        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr counts", count, 32'h0);
        check("clr keeps db", 32'(db), 32'h5);

        for (int i = 0; i < 300; i++) begin
            sw[2] = 1'b0;
            step(70);
            sw[2] = 1'b1;
            step(70);
        end
        check("ch2 wrap count", count, 32'h002C_0000);
        check("ch2 wrap pulses", pulse_cnt[2], 301);

        // Clear coincident with a channel-3 rise.
        to_tick_edge(3);
        sw[3] = 1'b1;
        to_tick_edge(3);
        check("ch3 W1A db", 32'(db[3]), 32'h0);
        to_tick_edge(3);
        check("ch3 W1B db", 32'(db[3]), 32'h0);
        wait_tick(3);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr+rise count", count, 32'h0);
        check("clr+rise db3", 32'(db[3]), 32'h1);
        check("clr+rise pulse", 32'(db_pulse), 32'h8);
        step(1);
        check("clr+rise pulse gone", 32'(db_pulse), 32'h0);

        // Reset with channel 0 parked in W1B.
        to_tick_edge(0);
        sw[0] = 1'b0;
        to_tick_edge(0);
        to_tick_edge(0);
        check("ch0 W0B db", 32'(db[0]), 32'h1);
        to_tick_edge(0);
        check("ch0 ZERO db", 32'(db[0]), 32'h0);
        sw[0] = 1'b1;
        to_tick_edge(0);
        to_tick_edge(0);
        check("ch0 W1B db", 32'(db[0]), 32'h0);
        saved_p0 = pulse_cnt[0];
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst db", 32'(db), 32'h0);
        check("async rst count", count, 32'h0);
        check("async rst ch_sel", 32'(ch_sel), 32'h0);
        check("async rst tick", 32'(tick), 32'h0);
        step(2);
        rst_n = 1'b1;
        wait_tick(0);
        check("post rst first ch", 32'(ch_sel), 32'h0);
        step(1);
        check("post rst svc1 db0", 32'(db[0]), 32'h0);
        to_tick_edge(0);
        check("post rst svc2 db0", 32'(db[0]), 32'h0);
        to_tick_edge(0);
        check("post rst svc3 db0", 32'(db[0]), 32'h1);
        check("post rst cnt0", 32'(count[7:0]), 32'h1);
        step(1);
        check("post rst pulses0", pulse_cnt[0], saved_p0 + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_scheduler.md
DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of switch channels, 2..16.
REQ-002 The block SHALL have parameter TICK_DIV, default 1_000_000: clock cycles per service tick, >=2.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_en, input, 1 bit: tick divider runs when high, holds when low.
REQ-006 The block SHALL have port i_clr, input, 1 bit: synchronous clear of all event counts.
REQ-007 The block SHALL have port i_sw, input, N_CH bits: raw asynchronous switch levels.
REQ-008 The block SHALL have port o_db, output, N_CH bits: debounced level per channel.
REQ-009 The block SHALL have port o_db_pulse, output, N_CH bits: one-cycle pulse per channel on each debounced rise.
REQ-010 The block SHALL have port o_count, output, N_CH*8 bits: packed 8-bit rise counts, channel k at bits [8k+7:8k].
REQ-011 The block SHALL have port o_ch_sel, output, $clog2(N_CH) bits: channel serviced on the current tick.
REQ-012 The block SHALL have port o_tick, output, 1 bit: high during the service-tick cycle.

Function
REQ-013 Each i_sw bit SHALL pass through a 2-flop synchronizer; only synchronized values (sync[k]) are used.
REQ-014 Divider SHALL count 0..TICK_DIV-1 while i_en=1, wrap to 0, and hold its value while i_en=0.
REQ-015 o_tick SHALL be 1 exactly when divider==TICK_DIV-1 and i_en=1.
REQ-016 On each tick edge, only channel o_ch_sel SHALL be serviced, then o_ch_sel SHALL advance by 1, wrapping N_CH-1 -> 0.
REQ-017 A single shared debounce engine SHALL service the selected channel from its 3-bit per-channel state register.
REQ-018 The state transitions for sample s=sync[ch] SHALL be: ZERO: s=1->W1A, else stay. W1A: s=1->W1B, s=0->ZERO. W1B: s=1->ONE, s=0->ZERO. ONE: s=0->W0A, else stay. W0A: s=0->W0B, s=1->ONE. W0B: s=0->ZERO, s=1->ONE.
REQ-019 o_db[k] SHALL be 1 when channel k state is ONE, W0A or W0B, and 0 otherwise; it is registered, so it changes on the tick edge.
REQ-020 A W1B->ONE transition on channel k SHALL assert o_db_pulse[k] for exactly the one cycle following the tick edge.
REQ-021 A W1B->ONE transition on channel k SHALL increment count k by 1, wrapping 255->0.
REQ-022 Unserviced channels SHALL hold their state, o_db bit and count.
REQ-023 i_clr=1 SHALL zero all counts on the next edge.
REQ-024 When i_clr and an increment coincide, the clear SHALL win and the count SHALL be 0.
REQ-025 i_clr SHALL NOT affect debounce state, o_db, o_db_pulse or o_ch_sel.
REQ-026 A glitch not present on 3 consecutive services of its channel SHALL NOT change o_db.
REQ-027 The worst-case debounce latency SHALL be 3*N_CH*TICK_DIV cycles plus 2 synchronizer cycles.

Reset
REQ-028 While i_rst=0, the synchronizers, divider, o_ch_sel, all states (ZERO), o_db, o_db_pulse, o_count and o_tick SHALL all be 0, asynchronously.
REQ-029 After reset deasserts, the first tick SHALL occur TICK_DIV cycles after the first enabled edge.
REQ-030 After reset deasserts, channel 0 SHALL be serviced first.
REQ-031 Reset asserted mid-operation SHALL abandon any partial debounce, with no pulse and no count change.

Verification (N_CH=4, TICK_DIV=4; channel k serviced every 16 cycles)
REQ-032 Hold i_sw=4'b0001 from reset, i_en=1 -> o_db[0] rises after the 3rd channel-0 service; one o_db_pulse[0]; count0=1; other channels 0.
REQ-033 Pulse i_sw[1] high for 20 cycles only -> o_db[1] stays 0 and count1 stays 0.
REQ-034 Toggle i_sw[2] 300 times with stable periods >64 cycles -> count2 wraps to 300 mod 256=44.
REQ-035 Assert i_clr on the same edge as a channel-3 rise -> count3=0, o_db[3]=1, o_db_pulse[3] still fires.
REQ-036 Drop i_en for 50 cycles mid-debounce -> divider and o_ch_sel frozen, no ticks, state resumes unchanged.
REQ-037 Assert i_rst with channel 0 in W1B -> all outputs 0 immediately, and after release 3 fresh services are needed.
